mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and byte sequencer between the instruction-fetch (IF) stage and the load/store (MEM) stage. It owns the byte-wide, synchronous-read RAM port. It serialises 1/2/4-byte accesses into per-byte RAM cycles and returns assembled little-endian data with a one-cycle done pulse. Its busy outputs feed the pipeline stall controller as `stall_if` / `stall_mem`.

## Interface

Parameters: none.

Ports:
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `if_req` input 1: IF requests a 4-byte instruction read.
- `if_addr` input 32: IF byte address.
- `if_done` output 1: one-cycle pulse; `if_data` valid this cycle.
- `if_data` output 32: fetched word, byte k in bits [8k+7:8k].
- `mem_req` input 1: MEM requests an access.
- `mem_we` input 1: 1 = store, 0 = load.
- `mem_width` input 2: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `mem_addr` input 32: MEM byte address.
- `mem_wdata` input 32: store data; byte k = bits [8k+7:8k].
- `mem_done` output 1: one-cycle pulse; load data valid / store committed.
- `mem_rdata` output 32: load data, low N bytes filled, upper bits zero (sign extension is done in MEM stage).
- `ram_din` input 8: RAM read data, valid the cycle after its address.
- `ram_dout` output 8: RAM write data.
- `ram_a` output 32: RAM byte address.
- `ram_wr` output 1: 1 = write `ram_dout` to `ram_a` at this edge.
- `stall_if` output 1: `if_req & ~if_done` (combinational).
- `stall_mem` output 1: `mem_req & ~mem_done` (combinational).

## Operation

- **FSM states:** IDLE, READ, WRITE, DONE.
- **Registers:** owner (IF/MEM), byte count N (1/2/4), issue counter k, capture counter, base address, write data, assembly buffer.
- **IDLE:** at the rising edge, sample requests and grant one of them.
  - Grant IF: READ with N=4.
  - Grant MEM load: READ with N from width.
  - Grant MEM store: WRITE.
  - No request: stay in IDLE.
- **Arbitration:** MEM has fixed priority over IF when both request in the same IDLE cycle. An access in progress is never preempted.
- **READ:** in issue cycle k (k = 0..N-1), `ram_a` = base+k. In cycle k+1, `ram_din` is captured into byte k. The last capture is in cycle N, after which the FSM goes to DONE (N+1 READ cycles).
- **WRITE:** in cycle k (k = 0..N-1), `ram_a` = base+k, `ram_dout` = data byte k, `ram_wr` = 1. After N cycles the FSM goes to DONE.
- **DONE:** one cycle.
  - The owner's done is high for this cycle; its data output is valid.
  - No requests are sampled. The requester must drop or update its req by the following edge.
  - Next state is IDLE.
- **Address arithmetic:** base+k is modulo 2^32 (wraps at 0xFFFFFFFF). No alignment is required.
- **Outputs outside READ/WRITE:** `ram_wr`=0, `ram_a`=0, `ram_dout`=0.
- **Data outputs:** `if_data` / `mem_rdata` hold their last value until the owner's next completion.
- **Request stability:** req, addr, width, we and wdata are latched at grant. Changes after grant are ignored.

## Timing

- **Reset values:** all outputs 0; state IDLE; counters 0; data registers 0.
- **Reset mid-access:** immediate return to IDLE; bytes already written stay written; no done pulse.
- **Read latency:** req high in IDLE cycle T → done in cycle T+N+2.
  - Word (IF): T+6.
  - Byte load: T+3.
- **Write latency:** req high in IDLE cycle T → done in cycle T+N+1.
  - Word store: T+5.
  - Byte store: T+2.
- **Back-to-back:** minimum one IDLE cycle between DONE and the next grant.
- **Throughput:** a word fetch occupies 7 cycles including IDLE.
- **Stall signals:** `stall_if` / `stall_mem` drop in the DONE cycle, so the stalled stage advances at the edge that ends DONE.

## Configuration

- **`MEM_ARB_RR_EN` defined:** round-robin arbitration.
  - A last-grant bit (reset = IF) is updated at every grant.
  - On simultaneous requests, the requester not granted last time wins.
- **`MEM_ARB_RR_EN` undefined:** fixed MEM-over-IF priority as in Operation; no last-grant bit is present.

## Test plan

- **Single fetch:** RAM[0x100..0x103]=11,22,33,44; `if_req`, `if_addr`=0x100 in cycle T.
  - `ram_a` = 0x100..0x103 in T+1..T+4.
  - `if_done` in T+6 with `if_data`=0x44332211.
  - `stall_if` is 1 in T..T+5.
- **Store then load:**
  - Half store `mem_wdata`=0xDEADBEEF at 0x200: `ram_wr` in two cycles, bytes EF, BE at 0x200, 0x201; `mem_done` at T+3.
  - Half load at 0x200 → `mem_rdata`=0x0000BEEF.
- **Simultaneous requests:** `if_req` and `mem_req` (word load) in the same cycle.
  - MEM granted first; IF done follows MEM done after DONE+IDLE.
  - With `MEM_ARB_RR_EN` and last grant = MEM, IF is granted first.
- **Wrap-around:** word load at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; bytes assembled in that order.
- **Reset mid-access:** assert `rst` after 2 bytes of a word store.
  - Outputs 0 immediately; only 2 bytes written; no `mem_done`.
  - A subsequent fetch completes normally.
- **Latched request:** change `mem_addr` after grant → access uses the granted address; `mem_width`=11 → 4 bytes.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/MEM request, byte-RAM and stall signals of mem_arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        stall_if;
    logic        stall_mem;
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, stall_if, stall_mem
    );
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte-RAM arbiter/sequencer for IF fetches and MEM loads/stores.
// Defining MEM_ARB_RR_EN switches simultaneous-request arbitration from MEM-first to round-robin.
module mem_arbiter (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  n_q, n_d, cnt_q, cnt_d;
    logic [31:0] base_q, base_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic        grant_mem;
    logic [1:0]  cap_idx;
    logic [31:0] addr_k;
`ifdef MEM_ARB_RR_EN
    logic        last_q, last_d;
    assign grant_mem = bus.mem_req & (~bus.if_req | ~last_q);
`else
    assign grant_mem = bus.mem_req;
`endif
    // owner_q = 1 means MEM; byte k is captured one cycle after its address is issued
    assign cap_idx = cnt_q[1:0] - 2'd1;
    assign addr_k  = base_q + {29'd0, cnt_q};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        bus.ram_a    = 32'd0;
        bus.ram_wr   = 1'b0;
        bus.ram_dout = 8'd0;
        case (state_q)
            IDLE: if (grant_mem || bus.if_req) begin
                owner_d = grant_mem;
                n_d     = !grant_mem ? 3'd4 : bus.mem_width == 2'b00 ? 3'd1 : bus.mem_width == 2'b01 ? 3'd2 : 3'd4;
                base_d  = grant_mem ? bus.mem_addr : bus.if_addr;
                wdata_d = bus.mem_wdata;
                cnt_d   = 3'd0;
                buf_d   = 32'd0;
                state_d = (grant_mem && bus.mem_we) ? WRITE : READ;
`ifdef MEM_ARB_RR_EN
                last_d  = grant_mem;
`endif
            end
            READ: begin
                bus.ram_a = (cnt_q < n_q) ? addr_k : 32'd0;
                if (cnt_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == n_q) begin
                    state_d = DONE;
                    if (owner_q) mem_rdata_d = buf_d;
                    else if_data_d = buf_d;
                end
            end
            WRITE: begin
                bus.ram_wr   = 1'b1;
                bus.ram_a    = addr_k;
                bus.ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == n_q - 3'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.if_done   = (state_q == DONE) && !owner_q;
    assign bus.mem_done  = (state_q == DONE) && owner_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.mem_req & ~bus.mem_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte-wide synchronous-read RAM model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] ram [4096];
    logic [31:0] wrap_a [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'hFFE] <= 8'hA1;
            ram[12'hFFF] <= 8'hB2;
            ram[12'h000] <= 8'hC3;
            ram[12'h001] <= 8'hD4;
        end else if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_a[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc();
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
    endtask

    task automatic mem_go(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_width = w;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
    endtask

    // called within request cycle T before its falling edge; reports cycles from T to done
    task automatic wait_done(input logic is_mem, input int exp_lat, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(is_mem ? bus.mem_done : bus.if_done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    initial begin
        int if_t, mem_t;
        logic seen;
        bus.if_req = 1'b0;
        bus.if_addr = 32'd0;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_width = 2'b00;
        bus.mem_addr = 32'd0;
        bus.mem_wdata = 32'd0;
        repeat (2) cyc();
        ram_init = 1'b0;
        mid();
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_ram_bus", {23'd0, bus.ram_wr, bus.ram_dout}, 32'd0);
        chk("rst_ram_a", bus.ram_a, 32'd0);
        cyc();
        rst = 1'b0;

        // single word fetch
        cyc();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        mid();
        chk("fetch_stall_T", 32'(bus.stall_if), 32'd1);
        chk("fetch_ram_a_T", bus.ram_a, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            mid();
            chk("fetch_ram_a", bus.ram_a, c <= 4 ? 32'(32'h100 + c - 1) : 32'd0);
            chk("fetch_stall", 32'(bus.stall_if), 32'd1);
            chk("fetch_no_done", 32'(bus.if_done), 32'd0);
        end
        cyc();
        mid();
        chk("fetch_done", 32'(bus.if_done), 32'd1);
        chk("fetch_data", bus.if_data, 32'h44332211);
        chk("fetch_stall_done", 32'(bus.stall_if), 32'd0);
        idle();
        mid();
        chk("fetch_done_pulse", 32'(bus.if_done), 32'd0);
        chk("fetch_data_hold", bus.if_data, 32'h44332211);

        // half store
        cyc();
        mem_go(1'b1, 2'b01, 32'h200, 32'hDEADBEEF);
        mid();
        chk("hst_stall", 32'(bus.stall_mem), 32'd1);
        cyc();
        mid();
        chk("hst_b0", {bus.ram_a[22:0], bus.ram_wr, bus.ram_dout}, {23'h200, 1'b1, 8'hEF});
        cyc();
        mid();
        chk("hst_b1", {bus.ram_a[22:0], bus.ram_wr, bus.ram_dout}, {23'h201, 1'b1, 8'hBE});
        cyc();
        mid();
        chk("hst_done", 32'(bus.mem_done), 32'd1);
        chk("hst_wr_off", 32'(bus.ram_wr), 32'd0);
        chk("hst_stall_done", 32'(bus.stall_mem), 32'd0);
        idle();
        chk("hst_ram", {ram[12'h200], ram[12'h201], ram[12'h202], 8'h00}, 32'hEFBE0000);

        // half load of the stored data
        cyc();
        mem_go(1'b0, 2'b01, 32'h200, 32'd0);
        wait_done(1'b1, 4, "hld_latency");
        chk("hld_data", bus.mem_rdata, 32'h0000BEEF);
        idle();

        // simultaneous IF and MEM word requests
        cyc();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        mem_go(1'b0, 2'b10, 32'h100, 32'd0);
        if_t = -1;
        mem_t = -1;
        for (int c = 0; c < 16; c++) begin
            mid();
            if (bus.if_done && if_t < 0) if_t = c;
            if (bus.mem_done && mem_t < 0) mem_t = c;
            cyc();
            if (if_t >= 0) bus.if_req = 1'b0;
            if (mem_t >= 0) bus.mem_req = 1'b0;
        end
`ifdef MEM_ARB_RR_EN
        chk("sim_if_time", if_t, 6);
        chk("sim_mem_time", mem_t, 13);
`else
        chk("sim_mem_time", mem_t, 6);
        chk("sim_if_time", if_t, 13);
`endif
        chk("sim_mem_data", bus.mem_rdata, 32'h44332211);
        chk("sim_if_data", bus.if_data, 32'h44332211);

        // word load wrapping past 0xFFFFFFFF
        cyc();
        mem_go(1'b0, 2'b10, 32'hFFFFFFFE, 32'd0);
        mid();
        for (int c = 1; c <= 4; c++) begin
            cyc();
            mid();
            chk("wrap_ram_a", bus.ram_a, wrap_a[c-1]);
        end
        cyc();
        cyc();
        mid();
        chk("wrap_done", 32'(bus.mem_done), 32'd1);
        chk("wrap_data", bus.mem_rdata, 32'hD4C3B2A1);
        idle();

        // reset after two bytes of a word store
        cyc();
        mem_go(1'b1, 2'b10, 32'h300, 32'h55667788);
        cyc();
        cyc();
        mid();
        chk("rmid_b1", {bus.ram_a[22:0], bus.ram_wr, bus.ram_dout}, {23'h301, 1'b1, 8'h77});
        cyc();
        rst = 1'b1;
        #1;
        chk("rmid_ram_bus", {23'd0, bus.ram_wr, bus.ram_dout}, 32'd0);
        chk("rmid_ram_a", bus.ram_a, 32'd0);
        chk("rmid_if_data", bus.if_data, 32'd0);
        chk("rmid_mem_rdata", bus.mem_rdata, 32'd0);
        bus.mem_req = 1'b0;
        cyc();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mid();
            seen = seen | bus.mem_done | bus.if_done;
            cyc();
        end
        chk("rmid_no_done", 32'(seen), 32'd0);
        chk("rmid_ram", {ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303]}, 32'h88770000);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        wait_done(1'b0, 6, "rmid_fetch_latency");
        chk("rmid_fetch_data", bus.if_data, 32'h44332211);
        idle();

        // request fields latched at grant, width 11 treated as word
        cyc();
        mem_go(1'b0, 2'b11, 32'h100, 32'd0);
        mid();
        cyc();
        bus.mem_addr = 32'h200;
        bus.mem_width = 2'b00;
        mid();
        chk("latch_ram_a1", bus.ram_a, 32'h100);
        for (int c = 2; c <= 5; c++) begin
            cyc();
            mid();
            chk("latch_ram_a", bus.ram_a, c <= 4 ? 32'(32'h100 + c - 1) : 32'd0);
        end
        cyc();
        mid();
        chk("latch_done", 32'(bus.mem_done), 32'd1);
        chk("latch_data", bus.mem_rdata, 32'h44332211);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
